// File: rtl/serial_add_ctrl.sv
//------------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder controller. A single full-adder cell is time-shared over
// WIDTH clock cycles to add two WIDTH-bit operands plus a carry-in, LSB first.
// Operands are captured on an accepted start. The registered sum and carry-out
// are published together with a one-cycle done pulse.
//
// Optional feature macro:
//   SERIAL_ADD_OVF_EN - adds the ovf output (two's-complement overflow of the
//                       last result), updated and held together with S/Co.
//
// Parameters:
//   WIDTH  operand / sum width in bits (2..32)
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-high
//   start  in   request; honoured only in IDLE or DONE
//   A, B   in   operands, captured on an accepted start
//   Ci     in   carry-in, captured on an accepted start
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when S and Co are updated
//   S      out  registered sum, holds the last result
//   ovf    out  registered signed overflow (SERIAL_ADD_OVF_EN only)
//   Co     out  registered carry-out, holds the last result
//------------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             Co
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    // Only WIDTH-1 result bits need storing: the final bit is taken straight
    // from the adder on the last RUN edge.
    logic [WIDTH-2:0]   r_sh;
    logic               r_c;
    logic [CNT_W-1:0]   r_cnt;

    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_s;
    logic               r_co;

    logic               w_accept;
    logic               w_last;
    logic               w_sum;
    logic               w_carry;
    logic [WIDTH-1:0]   w_sum_word;

    // Shared full-adder cell working on the current LSBs.
    assign w_sum      = r_a_sh[0] ^ r_b_sh[0] ^ r_c;
    assign w_carry    = (r_a_sh[0] & r_b_sh[0]) | ((r_a_sh[0] ^ r_b_sh[0]) & r_c);
    assign w_sum_word = {w_sum, r_sh};

    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_state == ST_RUN) && (r_cnt == LAST_CNT);

    //--------------------------------------------------------------------------
    // FSM state register
    //--------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    //--------------------------------------------------------------------------
    // FSM next-state logic
    //--------------------------------------------------------------------------
    // NOTE: the default assignment first guarantees every path assigns the
    // output, so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (start)  w_next_state = ST_RUN;
            ST_RUN:  if (w_last) w_next_state = ST_DONE;
            ST_DONE: w_next_state = start ? ST_RUN : ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath and registered outputs
    //--------------------------------------------------------------------------
    // NOTE: the shift registers are reset like ordinary flops because a
    // mid-operation reset must leave no residue of the discarded operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_sh   <= '0;
            r_c    <= 1'b0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_s    <= '0;
            r_co   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a_sh <= A;
                r_b_sh <= B;
                r_c    <= Ci;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_state == ST_RUN) begin
                r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
                r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                r_c    <= w_carry;
                r_sh   <= w_sum_word[WIDTH-1:1];
                if (w_last) begin
                    r_s    <= w_sum_word;
                    r_co   <= w_carry;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end else begin
                    // Counter never wraps: the last count leaves RUN.
                    r_cnt  <= r_cnt + 1'b1;
                end
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // On the last edge r_c is the carry into the MSB and w_carry the carry out.
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_c ^ w_carry;
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy = r_busy;
    assign done = r_done;
    assign S    = r_s;
    assign Co   = r_co;

endmodule

// File: tb/tb_serial_add_ctrl.sv
//------------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Scoreboard bench for serial_add_ctrl (WIDTH=4). The stimulus process pushes
// the hand-computed result and the cycle at which done must appear; a separate
// monitor pops and compares whenever done is observed.
//------------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Ci;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Co;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;
    exp_t sb[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Ci    (Ci),
        .busy  (busy),
        .done  (done),
        .S     (S),
`ifdef SERIAL_ADD_OVF_EN
        .ovf   (ovf),
`endif
        .Co    (Co)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [W-1:0] s, input logic co, input logic o, input int at);
        exp_t e;
        e.s = s; e.co = co; e.ovf = o; e.cyc = at;
        sb.push_back(e);
    endtask

    // One isolated operation from IDLE; returns in IDLE. Called at a negedge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic [W-1:0] es, input logic eco, input logic eovf);
        A = a; B = b; Ci = ci; start = 1'b1;
        push(es, eco, eovf, cyc + 1 + W);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        repeat (W) @(negedge clk);
        check("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("S", 32'(S), 32'(e.s));
                    check("Co", 32'(Co), 32'(e.co));
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
`ifdef SERIAL_ADD_OVF_EN
                    check("ovf", 32'(ovf), 32'(e.ovf));
`endif
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Ci = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_S", 32'(S), 32'd0);
        check("rst_Co", 32'(Co), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors: A, B, Ci -> S, Co, ovf
        run_op(4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0, 1'b1);
        run_op(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
        run_op(4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0);
        run_op(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
        run_op(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);
        run_op(4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b1, 1'b0);

        // start during RUN is ignored; S/Co hold the previous result meanwhile.
        A = 4'b0011; B = 4'b0101; Ci = 1'b0; start = 1'b1;
        push(4'b1000, 1'b0, 1'b1, cyc + 1 + W);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 4'b1111; B = 4'b1111; Ci = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_ignored_start", 32'(busy), 32'd1);
        check("S_hold_in_run", 32'(S), 32'd0);
        check("Co_hold_in_run", 32'(Co), 32'd1);
        repeat (2) @(negedge clk);
        check("busy_after_ignored", 32'(busy), 32'd0);
        @(negedge clk);

        // Reset in RUN cycle 2: operation discarded, outputs cleared, no done.
        A = 4'b0011; B = 4'b0101; Ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_S", 32'(S), 32'd0);
        check("midrst_Co", 32'(Co), 32'd0);
        repeat (W) @(negedge clk);
        run_op(4'b0110, 4'b0011, 1'b0, 4'b1001, 1'b0, 1'b1);

        // Back-to-back with start held high; operands change after capture.
        c = cyc;
        A = 4'b0001; B = 4'b0001; Ci = 1'b0; start = 1'b1;
        push(4'b0010, 1'b0, 1'b0, c + 1 + W);
        push(4'b0100, 1'b0, 1'b0, c + 2 + 2 * W);
        @(negedge clk);
        A = 4'b0010; B = 4'b0010;
        repeat (W) @(negedge clk);
        @(negedge clk);
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done_low", 32'(done), 32'd0);
        start = 1'b0;
        repeat (W) @(negedge clk);
        repeat (3) @(negedge clk);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
